// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared state and mux-select encodings for the MCU sequencer
package mcu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RD    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_WR    = 3'd5,
        ST_DONE  = 3'd6
    } mcu_state_e;

    localparam logic SEL_HOST = 1'b0;
    localparam logic SEL_CONV = 1'b1;
    localparam logic HALF_LO  = 1'b0;
    localparam logic HALF_HI  = 1'b1;

endpackage

// File: rtl/mcu_sequencer.sv
// rtl/mcu_sequencer.sv - control FSM sequencing host LOAD batches and row-by-row convolution RUN
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int N           = 2,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_ADDR   = 10,
    parameter int RD_LAT      = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BITS_ADDR-1:0] i_length,
    input  logic                 i_load,
    input  logic                 i_valid,
    input  logic                 i_run,
    output logic                 o_inputCtrl,
    output logic                 o_memCtrl,
    output logic                 o_convCtrl,
    output logic [BITS_ADDR-1:0] o_rd_addr,
    output logic [BITS_ADDR-1:0] o_wr_addr,
    output logic                 o_we,
    output logic                 o_conv_en,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int         WORD_W    = (N + 2) * BITS_IMAGEN;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    mcu_state_e           state_q, state_d;
    logic [BITS_ADDR-1:0] r_q, r_d;
    logic [BITS_ADDR-1:0] len_q, len_d;
    logic                 h_q, h_d;
    logic [1:0]           wcnt_q, wcnt_d;
    logic [BITS_ADDR-1:0] last_row;

    // L=0 wraps to all ones here, which makes it behave as a 2**BITS_ADDR-row image
    assign last_row = len_q - BITS_ADDR'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            len_q   <= '0;
            h_q     <= HALF_LO;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            len_q   <= len_d;
            h_q     <= h_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        len_d       = len_q;
        h_d         = h_q;
        wcnt_d      = wcnt_q;
        o_inputCtrl = SEL_HOST;
        o_memCtrl   = HALF_LO;
        o_convCtrl  = 1'b0;
        o_rd_addr   = '0;
        o_wr_addr   = '0;
        o_we        = 1'b0;
        o_conv_en   = 1'b0;
        o_done      = 1'b0;
        o_busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    state_d = ST_LOAD;
                    r_d     = '0;
                    len_d   = i_length;
                end else if (i_run) begin
                    state_d = ST_RD;
                    r_d     = '0;
                    len_d   = i_length;
                end
            end
            ST_LOAD: begin
                o_inputCtrl = SEL_HOST;
                o_memCtrl   = h_q;
                if (i_valid) begin
                    o_we      = 1'b1;
                    o_wr_addr = r_q;
                    r_d       = r_q + BITS_ADDR'(1);
                    if (r_q == last_row) begin
                        state_d = ST_DONE;
                        h_d     = ~h_q;
                    end
                end
            end
            ST_RD: begin
                o_convCtrl = h_q;
                o_rd_addr  = r_q;
                wcnt_d     = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                o_convCtrl = h_q;
                o_rd_addr  = r_q;
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_SHIFT;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            ST_SHIFT: begin
                o_convCtrl = h_q;
                o_conv_en  = 1'b1;
                // a full 3-row window exists only once rows r-2..r have been shifted in
                if (r_q >= BITS_ADDR'(2)) begin
                    state_d = ST_WR;
                end else begin
                    r_d     = r_q + BITS_ADDR'(1);
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                o_convCtrl  = h_q;
                o_inputCtrl = SEL_CONV;
                o_memCtrl   = ~h_q;
                o_we        = 1'b1;
                o_wr_addr   = r_q - BITS_ADDR'(1);
                if (r_q == last_row) begin
                    state_d = ST_DONE;
                end else begin
                    r_d     = r_q + BITS_ADDR'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb/tb_mcu_sequencer.sv - directed self-checking bench for mcu_sequencer
module tb_mcu_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [9:0] i_length;
    logic       i_load, i_valid, i_run;
    logic       o_inputCtrl, o_memCtrl, o_convCtrl;
    logic [9:0] o_rd_addr, o_wr_addr;
    logic       o_we, o_conv_en, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mcu_sequencer #(.N(2), .BITS_IMAGEN(8), .BITS_ADDR(10), .RD_LAT(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_length(i_length),
        .i_load(i_load), .i_valid(i_valid), .i_run(i_run),
        .o_inputCtrl(o_inputCtrl), .o_memCtrl(o_memCtrl), .o_convCtrl(o_convCtrl),
        .o_rd_addr(o_rd_addr), .o_wr_addr(o_wr_addr), .o_we(o_we),
        .o_conv_en(o_conv_en), .o_busy(o_busy), .o_done(o_done)
    );

    function automatic logic [29:0] pack_outs();
        return {o_inputCtrl, o_memCtrl, o_convCtrl, o_we, o_conv_en, o_busy, o_done,
                o_rd_addr, o_wr_addr, 3'b000};
    endfunction

    task automatic test_reset();
        i_rst = 1'b1; i_length = '0; i_load = 0; i_valid = 0; i_run = 0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (pack_outs() !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", pack_outs());
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_after_release: got %b expected 0", o_busy);
        end
    endtask

    // one LOAD batch of len pixel pairs, i_valid pulses separated by 2 idle cycles
    task automatic load_batch(input logic [9:0] len, input logic exp_h, input bit with_run);
        @(negedge i_clk);
        i_length = len; i_load = 1'b1; i_run = with_run;
        @(negedge i_clk);
        i_load = 1'b0; i_run = 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            repeat (2) begin
                checks++;
                if (o_we !== 1'b0 || o_busy !== 1'b1 || o_conv_en !== 1'b0) begin
                    errors++;
                    $display("FAIL load_gap: we=%b busy=%b conv_en=%b expected 0,1,0", o_we, o_busy, o_conv_en);
                end
                @(negedge i_clk);
            end
            i_valid = 1'b1;
            #1;
            checks++;
            if (o_we !== 1'b1 || o_wr_addr !== 10'(k) || o_memCtrl !== exp_h || o_inputCtrl !== 1'b0) begin
                errors++;
                $display("FAIL load_write%0d: we=%b addr=%0d mem=%b in=%b expected 1,%0d,%b,0",
                         k, o_we, o_wr_addr, o_memCtrl, o_inputCtrl, k, exp_h);
            end
            @(negedge i_clk);
            i_valid = 1'b0;
            #1;
        end
        checks++;
        if (o_done !== 1'b1 || o_we !== 1'b0) begin
            errors++;
            $display("FAIL load_done: done=%b we=%b expected 1,0", o_done, o_we);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: done=%b busy=%b expected 0,0", o_done, o_busy);
        end
    endtask

    task automatic test_load();
        load_batch(10'd4, 1'b0, 1'b0);
        load_batch(10'd4, 1'b1, 1'b0);
        load_batch(10'd4, 1'b0, 1'b0);
    endtask

    // RUN of len rows; cycle 0 is the first RD cycle, DONE expected at 3*2 + 4*(len-2)
    task automatic run_check(input logic [9:0] len, input logic exp_h, input bit poke);
        int cyc, n_en, n_we, done_cyc, exp_done;
        logic [9:0] prev_rd;
        exp_done = 6 + 4 * (int'(len) - 2);
        cyc = 0; n_en = 0; n_we = 0; done_cyc = -1; prev_rd = '0;
        @(negedge i_clk);
        i_length = len; i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            i_run = (poke && cyc == 5);
            if (o_conv_en) begin
                checks++;
                if (prev_rd !== 10'(n_en)) begin
                    errors++;
                    $display("FAIL run_rd_addr: got %0d expected %0d", prev_rd, n_en);
                end
                n_en++;
            end
            if (o_we) begin
                checks++;
                if (o_wr_addr !== 10'(n_we + 1) || o_inputCtrl !== 1'b1 || o_memCtrl !== ~exp_h) begin
                    errors++;
                    $display("FAIL run_write%0d: addr=%0d in=%b mem=%b expected %0d,1,%b",
                             n_we, o_wr_addr, o_inputCtrl, o_memCtrl, n_we + 1, ~exp_h);
                end
                n_we++;
            end
            if (o_done) begin
                done_cyc = cyc;
            end else begin
                checks++;
                if (o_convCtrl !== exp_h || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL run_conv_ctrl cyc%0d: conv=%b busy=%b expected %b,1", cyc, o_convCtrl, o_busy, exp_h);
                end
            end
            prev_rd = o_rd_addr;
            @(negedge i_clk);
            cyc++;
        end
        i_run = 1'b0;
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL run_done_cycle: got %0d expected %0d", done_cyc, exp_done);
        end
        checks++;
        if (n_en != int'(len) || n_we != int'(len) - 2) begin
            errors++;
            $display("FAIL run_counts: conv_en=%0d we=%0d expected %0d,%0d", n_en, n_we, len, len - 2);
        end
        checks++;
        if (o_busy !== 1'b0 || o_convCtrl !== 1'b0) begin
            errors++;
            $display("FAIL run_idle: busy=%b conv=%b expected 0,0", o_busy, o_convCtrl);
        end
    endtask

    task automatic test_run_high_half();
        run_check(10'd5, 1'b1, 1'b0);
    endtask

    task automatic test_priority_and_ignore();
        load_batch(10'd4, 1'b1, 1'b1);
        run_check(10'd5, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int guard;
        guard = 0;
        @(negedge i_clk);
        i_length = 10'd5; i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        while (o_we !== 1'b1 && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        checks++;
        if (o_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_run_reach_wr: we=%b expected 1", o_we);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (pack_outs() !== 30'd0) begin
            errors++;
            $display("FAIL reset_mid_run_outputs: got %h expected 0", pack_outs());
        end
        @(negedge i_clk);
        checks++;
        if (o_we !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: we=%b busy=%b expected 0,0", o_we, o_busy);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b we=%b expected 0,0", o_busy, o_we);
        end
        run_check(10'd5, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_high_half();
        test_priority_and_ignore();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
